// File: rtl/imm_ext_unit.sv
// Registered immediate extension unit with a one-deep prefix register for wide immediates.
// Produces an extended operand and a shifted copy one cycle after each non-PREFIX acceptance.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no prefix held; source is imm_in alone
// ST_PENDING | prefix_q holds the upper half of the next wide immediate
module imm_ext_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [2:0]        mode,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] imm_shift,
    output logic              prefix_pending,
    output logic              mode_err
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [2:0] MODE_ZERO   = 3'b000;
    localparam logic [2:0] MODE_SIGN   = 3'b001;
    localparam logic [2:0] MODE_UPPER  = 3'b010;
    localparam logic [2:0] MODE_PREFIX = 3'b011;

    localparam int NARROW_W = IMM_W;
    localparam int WIDE_W   = 2 * IMM_W;

    state_t              state_q, state_d;
    logic [IMM_W-1:0]    prefix_q, prefix_d;
    logic                out_valid_q, out_valid_d;
    logic                mode_err_q, mode_err_d;
    logic [DATA_W-1:0]   imm_out_q, imm_out_d;
    logic [DATA_W-1:0]   imm_shift_q, imm_shift_d;

    logic                pending_eff;
    logic [WIDE_W-1:0]   src;
    logic                src_sign;
    int                  src_w;
    logic [DATA_W-1:0]   ext_zero;
    logic [DATA_W-1:0]   ext_sign;
    logic [DATA_W-1:0]   upper_out;
    logic [DATA_W-1:0]   upper_shift;

    // flush takes effect before the input at the same edge, so it masks the held prefix here
    assign pending_eff = (state_q == ST_PENDING) && !flush;

    always_comb begin
        src      = {WIDE_W{1'b0}};
        src_sign = 1'b0;
        src_w    = NARROW_W;
        if (pending_eff) begin
            src      = {prefix_q, imm_in};
            src_sign = prefix_q[IMM_W-1];
            src_w    = WIDE_W;
        end else begin
            src[IMM_W-1:0] = imm_in;
            src_sign       = imm_in[IMM_W-1];
            src_w          = NARROW_W;
        end
    end

    assign ext_zero = DATA_W'(src);

    always_comb begin
        ext_sign = ext_zero;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= src_w) begin
                ext_sign[i] = src_sign;
            end
        end
    end

    assign upper_out   = DATA_W'(imm_in) << (DATA_W - IMM_W);
    assign upper_shift = DATA_W'(imm_in) << SHIFT;

    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        out_valid_d = 1'b0;
        mode_err_d  = 1'b0;
        imm_out_d   = imm_out_q;
        imm_shift_d = imm_shift_q;

        if (flush) begin
            state_d = ST_IDLE;
        end

        if (in_valid) begin
            if (mode == MODE_PREFIX) begin
                prefix_d = imm_in;
                state_d  = ST_PENDING;
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                mode_err_d  = mode[2];
                case (mode)
                    MODE_SIGN: begin
                        imm_out_d   = ext_sign;
                        imm_shift_d = ext_sign << SHIFT;
                    end
                    MODE_UPPER: begin
                        imm_out_d   = upper_out;
                        imm_shift_d = upper_shift;
                    end
                    // ZERO and the reserved 1xx codes both zero-extend
                    default: begin
                        imm_out_d   = ext_zero;
                        imm_shift_d = ext_zero << SHIFT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
            mode_err_q  <= 1'b0;
            imm_out_q   <= '0;
            imm_shift_q <= '0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            out_valid_q <= out_valid_d;
            mode_err_q  <= mode_err_d;
            imm_out_q   <= imm_out_d;
            imm_shift_q <= imm_shift_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign mode_err       = mode_err_q;
    assign imm_out        = imm_out_q;
    assign imm_shift      = imm_shift_q;
    assign prefix_pending = (state_q == ST_PENDING);

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: hand-computed vectors, immediate assertions at each check.
module tb_imm_ext_unit;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int SHIFT  = 2;

    localparam logic [2:0] M_ZERO   = 3'b000;
    localparam logic [2:0] M_SIGN   = 3'b001;
    localparam logic [2:0] M_UPPER  = 3'b010;
    localparam logic [2:0] M_PREFIX = 3'b011;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [IMM_W-1:0]  imm_in;
    logic [2:0]        mode;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] imm_out;
    logic [DATA_W-1:0] imm_shift;
    logic              prefix_pending;
    logic              mode_err;

    int n_checks = 0;
    int n_fail   = 0;

    imm_ext_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHIFT(SHIFT)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .imm_in         (imm_in),
        .mode           (mode),
        .flush          (flush),
        .out_valid      (out_valid),
        .imm_out        (imm_out),
        .imm_shift      (imm_shift),
        .prefix_pending (prefix_pending),
        .mode_err       (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs at negedge, sample #1 after the following posedge
    task automatic step(input logic v, input logic [2:0] m, input logic [15:0] imm, input logic fl);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        imm_in   = imm;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic ov, input logic [31:0] o,
                             input logic [31:0] s, input logic pp, input logic err);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".imm_out"}, imm_out, o);
        check({tag, ".imm_shift"}, imm_shift, s);
        check({tag, ".prefix_pending"}, {31'd0, prefix_pending}, {31'd0, pp});
        check({tag, ".mode_err"}, {31'd0, mode_err}, {31'd0, err});
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        imm_in   = '0;
        mode     = M_ZERO;
        flush    = 1'b0;
        #12;
        check_res("reset_init", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, M_SIGN, 16'h8004, 1'b0);
        check_res("sign_8004", 1'b1, 32'hFFFF8004, 32'hFFFE0010, 1'b0, 1'b0);
        step(1'b0, M_SIGN, 16'h0000, 1'b0);
        check_res("sign_hold", 1'b0, 32'hFFFF8004, 32'hFFFE0010, 1'b0, 1'b0);

        // asynchronous reset mid-cycle, then hold it across an edge with in_valid high
        #3;
        reset = 1'b1;
        #1;
        check_res("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, M_SIGN, 16'h8004, 1'b0);
        check_res("rst_hold_valid", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, M_ZERO, 16'h8004, 1'b0);
        check_res("zero_8004", 1'b1, 32'h00008004, 32'h00020010, 1'b0, 1'b0);
        step(1'b1, M_UPPER, 16'h1234, 1'b0);
        check_res("upper_1234", 1'b1, 32'h12340000, 32'h000048D0, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'hABCD, 1'b0);
        check_res("prefix_abcd", 1'b0, 32'h12340000, 32'h000048D0, 1'b1, 1'b0);
        step(1'b1, M_SIGN, 16'h0001, 1'b0);
        check_res("wide_sign", 1'b1, 32'hABCD0001, 32'hAF340004, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'h1111, 1'b0);
        step(1'b1, M_PREFIX, 16'h2222, 1'b0);
        check({"prefix_twice.pp"}, {31'd0, prefix_pending}, 32'd1);
        step(1'b1, M_ZERO, 16'h0003, 1'b0);
        check_res("prefix_last_wins", 1'b1, 32'h22220003, 32'h8888000C, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'h1111, 1'b0);
        step(1'b0, M_ZERO, 16'h0000, 1'b1);
        check_res("flush_only", 1'b0, 32'h22220003, 32'h8888000C, 1'b0, 1'b0);
        step(1'b1, M_ZERO, 16'h00FF, 1'b0);
        check_res("after_flush", 1'b1, 32'h000000FF, 32'h000003FC, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'h3333, 1'b1);
        check_res("flush_with_prefix", 1'b0, 32'h000000FF, 32'h000003FC, 1'b1, 1'b0);
        step(1'b1, M_SIGN, 16'h0002, 1'b0);
        check_res("flush_prefix_used", 1'b1, 32'h33330002, 32'hCCCC0008, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'h4444, 1'b0);
        step(1'b1, M_SIGN, 16'h8000, 1'b1);
        check_res("flush_with_sign", 1'b1, 32'hFFFF8000, 32'hFFFE0000, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'h8000, 1'b0);
        check({"prefix_8000.pp"}, {31'd0, prefix_pending}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_res("rst_clears_prefix", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, M_SIGN, 16'hFFFF, 1'b0);
        check_res("sign_ffff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0, 1'b0);

        step(1'b1, 3'b101, 16'h8001, 1'b0);
        check_res("reserved_101", 1'b1, 32'h00008001, 32'h00020004, 1'b0, 1'b1);
        step(1'b0, M_ZERO, 16'h0000, 1'b0);
        check_res("reserved_drop", 1'b0, 32'h00008001, 32'h00020004, 1'b0, 1'b0);

        step(1'b1, M_PREFIX, 16'h8000, 1'b0);
        step(1'b1, 3'b111, 16'h0001, 1'b0);
        check_res("reserved_wide", 1'b1, 32'h80000001, 32'h00000004, 1'b0, 1'b1);

        step(1'b1, M_PREFIX, 16'h5555, 1'b0);
        step(1'b1, M_UPPER, 16'h00FF, 1'b0);
        check_res("upper_eats_prefix", 1'b1, 32'h00FF0000, 32'h000003FC, 1'b0, 1'b0);

        step(1'b1, M_SIGN, 16'h7FFF, 1'b0);
        check_res("b2b_sign", 1'b1, 32'h00007FFF, 32'h0001FFFC, 1'b0, 1'b0);
        step(1'b1, M_ZERO, 16'hFFFF, 1'b0);
        check_res("b2b_zero", 1'b1, 32'h0000FFFF, 32'h0003FFFC, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_unit.md
# imm_ext_unit

Registered, parametrised immediate extension unit for the multi-cycle datapath. It takes an IMM_W-bit instruction immediate and a mode, then produces a DATA_W-bit extended operand and a shifted copy for branch-offset use, one cycle after acceptance. It adds a prefix mechanism: a PREFIX operation loads the upper half of a wide immediate, and the next non-prefix operation supplies the lower half. The unit sits between the instruction register and the ALU-source / PC-target muxes.

## Interface
- DATA_W, 32, output operand width; DATA_W >= 2*IMM_W required
- IMM_W, 16, instruction immediate width; IMM_W >= 2
- SHIFT, 2, left-shift amount for imm_shift; SHIFT < DATA_W
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  imm_in/mode are presented and accepted this edge
- imm_in  input  IMM_W  raw immediate field
- mode  input  3  000 ZERO, 001 SIGN, 010 UPPER, 011 PREFIX, 1xx reserved
- flush  input  1  discard any pending prefix
- out_valid  output  1  one-cycle pulse: imm_out/imm_shift hold a new result
- imm_out  output  DATA_W  extended operand
- imm_shift  output  DATA_W  extension (pre-UPPER) << SHIFT, truncated to DATA_W
- prefix_pending  output  1  prefix register holds an unconsumed value
- mode_err  output  1  one-cycle pulse: the accepted mode was reserved

## Operation
- States: IDLE (prefix_pending=0) and PENDING (prefix_pending=1). prefix_reg is IMM_W bits.
- Source value S:
  - In IDLE: S = imm_in, of width IMM_W, with sign bit imm_in[IMM_W-1].
  - In PENDING: S = {prefix_reg, imm_in}, of width 2*IMM_W, with sign bit prefix_reg[IMM_W-1].
- ZERO: ext = S zero-extended to DATA_W.
- SIGN: ext = S sign-extended to DATA_W.
- In both cases: imm_out = ext; imm_shift = ext << SHIFT.
- UPPER:
  - imm_out = imm_in << (DATA_W-IMM_W), lower bits zero.
  - imm_shift = zero-extended imm_in << SHIFT.
  - Any pending prefix is consumed and ignored.
- PREFIX:
  - prefix_reg <= imm_in; state goes to PENDING.
  - No out_valid; imm_out and imm_shift are unchanged.
  - PREFIX while already in PENDING overwrites prefix_reg (last wins) and stays in PENDING.
- Reserved mode (1xx):
  - Treated as ZERO using the current S.
  - out_valid and mode_err both pulse.
  - A pending prefix is consumed.
- Every accepted non-PREFIX operation returns the state to IDLE.
- flush:
  - Clears prefix_pending at the edge.
  - If in_valid is high at the same edge, flush applies first: the input is processed as from IDLE, and a PREFIX input reloads the prefix and leaves the state in PENDING.
- in_valid low: no state change, except for flush; outputs hold, and pulses drop.

## Timing
- Latency: an input accepted at edge N produces a result visible after edge N. out_valid is high for exactly that one cycle.
- Back-to-back acceptance is allowed every cycle. Throughput is one result per cycle, except PREFIX cycles, which produce no result.
- imm_out and imm_shift are registered and hold their last result until the next non-PREFIX acceptance. They are not cleared when out_valid drops.
- Reset (asynchronous, immediate, including mid-operation) sets: out_valid=0, mode_err=0, imm_out=0, imm_shift=0, prefix_pending=0, prefix_reg=0.
- The first edge after reset deassertion may accept an input.
- No combinational path from any input to any output.

## Test plan
Defaults for all scenarios: DATA_W=32, IMM_W=16, SHIFT=2.
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately. Hold reset with in_valid=1 -> outputs stay 0.
- SIGN 0x8004 -> next cycle: out_valid=1, imm_out=0xFFFF8004, imm_shift=0xFFFE0010; the following cycle out_valid=0 and the values hold.
- ZERO 0x8004 -> imm_out=0x00008004, imm_shift=0x00020010.
- UPPER 0x1234 -> imm_out=0x12340000, imm_shift=0x000048D0.
- PREFIX 0xABCD, then SIGN 0x0001 -> after the first edge: prefix_pending=1, out_valid=0. After the second: imm_out=0xABCD0001, imm_shift=0xAF340004, prefix_pending=0.
- PREFIX 0x1111, PREFIX 0x2222, then ZERO 0x0003 -> imm_out=0x22220003.
- PREFIX 0x1111, then flush, then ZERO 0x00FF -> imm_out=0x000000FF.
- flush with PREFIX 0x3333 at the same edge -> prefix_pending=1.
- PREFIX 0x8000, then async reset -> prefix_pending=0 immediately. Then SIGN 0xFFFF -> imm_out=0xFFFFFFFF.
- Reserved mode 3'b101 with imm 0x8001 -> out_valid=1, mode_err=1, imm_out=0x00008001.
